// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, synchronous-read instruction memory drive and F/D capture.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc,
    input  logic        i_redirect,
    input  logic        i_stall,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_en,
    input  logic [31:0] i_imem_dout,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_fd,
    output logic [31:0] o_inst_fd,
    output logic        o_valid_fd,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_bubble_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_valid_fd;
    logic        r_imem_en;
    logic [31:0] r_pc;
    logic [31:0] r_pc_fd;
    logic [31:0] r_hold;
    logic [31:0] w_next_pc_al;
    logic        w_advance;

    assign w_next_pc_al = i_next_pc & 32'hFFFF_FFFC;
    assign w_advance    = i_redirect | ~i_stall;

    // The read enable is registered from the next state: the edge that enters HOLD
    // still reads pc, so the memory already holds the instruction needed on release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_BOOT;
            r_valid_fd <= 1'b0;
            r_imem_en  <= 1'b1;
        end else begin
            case (r_state)
                S_BOOT, S_RUN, S_FLUSH: begin
                    if (i_redirect) begin
                        r_state    <= S_FLUSH;
                        r_valid_fd <= 1'b0;
                        r_imem_en  <= 1'b1;
                    end else if (i_stall) begin
                        r_state    <= S_HOLD;
                        r_valid_fd <= (r_state == S_RUN);
                        r_imem_en  <= 1'b0;
                    end else begin
                        r_state    <= S_RUN;
                        r_valid_fd <= 1'b1;
                        r_imem_en  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_redirect) begin
                        r_state    <= S_FLUSH;
                        r_valid_fd <= 1'b0;
                        r_imem_en  <= 1'b1;
                    end else if (!i_stall) begin
                        r_state    <= S_RUN;
                        r_valid_fd <= 1'b1;
                        r_imem_en  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_valid_fd <= 1'b0;
                    r_imem_en  <= 1'b1;
                end
            endcase
        end
    end

    // F/D instruction is captured on HOLD entry, before the memory moves on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc    <= RESET_PC;
            r_pc_fd <= 32'h0;
            r_hold  <= NOP_INST;
        end else if (w_advance) begin
            r_pc    <= w_next_pc_al;
            r_pc_fd <= r_pc;
        end else if (r_state != S_HOLD) begin
            r_hold  <= i_imem_dout;
        end
    end

    assign o_pc        = r_pc;
    assign o_imem_addr = r_pc;
    assign o_imem_en   = r_imem_en;
    assign o_pc_fd     = r_pc_fd;
    assign o_valid_fd  = r_valid_fd;
    assign o_inst_fd   = !r_valid_fd         ? NOP_INST :
                         (r_state == S_HOLD) ? r_hold   : i_imem_dout;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt  <= 32'h0;
            r_bubble_cnt <= 32'h0;
        end else begin
            if (r_valid_fd && w_advance)
                r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            if (!r_valid_fd)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt  = r_fetch_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_fetch_cnt  = 32'h0;
    assign o_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a sync-read memory model, per-cycle expectations
// queued when stimulus is driven and checked one cycle later.
module tb_fetch_pc_unit;

    localparam logic [31:0] A   = 32'h4000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        use_np = 1'b0;
    logic [31:0] np_val = 32'h0;
    logic [31:0] next_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_dout = 32'h0;
    logic [31:0] pc, pc_fd, inst_fd, fetch_cnt, bubble_cnt;
    logic        valid_fd;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int mf = 0;
    int mb = 0;
    logic cur_valid = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_fd;
        logic [31:0] inst;
        logic        valid;
        logic        en;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;
    exp_t sbq[$];

    fetch_pc_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_next_pc   (next_pc),
        .i_redirect  (redirect),
        .i_stall     (stall),
        .o_imem_addr (imem_addr),
        .o_imem_en   (imem_en),
        .i_imem_dout (imem_dout),
        .o_pc        (pc),
        .o_pc_fd     (pc_fd),
        .o_inst_fd   (inst_fd),
        .o_valid_fd  (valid_fd),
        .o_fetch_cnt (fetch_cnt),
        .o_bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'h4000_0008) return 32'h0010_0093;
        return a ^ 32'h0000_0F33;
    endfunction

    always @(posedge clk) if (imem_en) imem_dout <= inst_of(imem_addr);

    assign next_pc = use_np ? np_val : pc + 32'd4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd, input logic un,
                        input logic [31:0] nv, input logic [31:0] e_pc, input logic [31:0] e_pcfd,
                        input logic [31:0] e_inst, input logic e_valid, input logic e_en);
        exp_t e;
        exp_t g;
        rst = r; stall = s; redirect = rd; use_np = un; np_val = nv;
        if (r) begin
            mf = 0; mb = 0;
        end else if (!cur_valid) begin
            mb++;
        end else if (!s || rd) begin
            mf++;
        end
        cur_valid = e_valid;
        e.pc = e_pc; e.pc_fd = e_pcfd; e.inst = e_inst; e.valid = e_valid; e.en = e_en;
`ifdef FETCH_PERF_CNT_EN
        e.fc = 32'(mf); e.bc = 32'(mb);
`else
        e.fc = 32'h0; e.bc = 32'h0;
`endif
        sbq.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        g = sbq.pop_front();
        chk("pc", pc, g.pc);
        chk("imem_addr", imem_addr, g.pc);
        chk("pc_fd", pc_fd, g.pc_fd);
        chk("inst_fd", inst_fd, g.inst);
        chk("valid_fd", {31'h0, valid_fd}, {31'h0, g.valid});
        chk("imem_en", {31'h0, imem_en}, {31'h0, g.en});
        chk("fetch_cnt", fetch_cnt, g.fc);
        chk("bubble_cnt", bubble_cnt, g.bc);
    endtask

    initial begin
        // reset for two cycles, then sequential fetch
        step(1, 0, 0, 0, 0, A,        32'h0,    NOP,            0, 1);
        step(1, 0, 0, 0, 0, A,        32'h0,    NOP,            0, 1);
        step(0, 0, 0, 0, 0, A + 4,    A,        inst_of(A),     1, 1);
        step(0, 0, 0, 0, 0, A + 8,    A + 4,    inst_of(A + 4), 1, 1);
        step(0, 0, 0, 0, 0, A + 12,   A + 8,    32'h0010_0093,  1, 1);
        // three-cycle stall
        step(0, 1, 0, 0, 0, A + 12,   A + 8,    32'h0010_0093,  1, 0);
        step(0, 1, 0, 0, 0, A + 12,   A + 8,    32'h0010_0093,  1, 0);
        step(0, 1, 0, 0, 0, A + 12,   A + 8,    32'h0010_0093,  1, 0);
        step(0, 0, 0, 0, 0, A + 16,   A + 12,   inst_of(A + 12), 1, 1);
        step(0, 0, 0, 0, 0, A + 20,   A + 16,   inst_of(A + 16), 1, 1);
        // redirect with one-bubble penalty
        step(0, 0, 1, 1, A + 32'h100, A + 32'h100, A + 20,      NOP, 0, 1);
        step(0, 0, 0, 0, 0, A + 32'h104, A + 32'h100, inst_of(A + 32'h100), 1, 1);
        // redirect and stall in the same cycle
        step(0, 1, 1, 1, A + 32'h200, A + 32'h200, A + 32'h104, NOP, 0, 1);
        step(0, 0, 0, 0, 0, A + 32'h204, A + 32'h200, inst_of(A + 32'h200), 1, 1);
        // redirect in the middle of a two-cycle stall
        step(0, 1, 0, 0, 0, A + 32'h204, A + 32'h200, inst_of(A + 32'h200), 1, 0);
        step(0, 1, 1, 1, A + 32'h300, A + 32'h300, A + 32'h204, NOP, 0, 1);
        step(0, 0, 0, 0, 0, A + 32'h304, A + 32'h300, inst_of(A + 32'h300), 1, 1);
        // misaligned target and address wrap
        step(0, 0, 0, 1, A + 32'h106, A + 32'h104, A + 32'h304, inst_of(A + 32'h304), 1, 1);
        step(0, 0, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, A + 32'h104, NOP, 0, 1);
        step(0, 0, 0, 0, 0, 32'h0,    32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1, 1);
        step(0, 0, 0, 0, 0, 32'h4,    32'h0,    inst_of(32'h0), 1, 1);
        // reset during HOLD, then stall straight out of reset
        step(0, 1, 0, 0, 0, 32'h4,    32'h0,    inst_of(32'h0), 1, 0);
        step(1, 1, 0, 0, 0, A,        32'h0,    NOP,            0, 1);
        step(0, 1, 0, 0, 0, A,        32'h0,    NOP,            0, 0);
        step(0, 0, 0, 0, 0, A + 4,    A,        inst_of(A),     1, 1);
        step(0, 0, 0, 0, 0, A + 8,    A + 4,    inst_of(A + 4), 1, 1);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
